// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS PC/next-PC stage.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_PC4 = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } npc_sel_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/npc_sel.sv
// Next-PC target arithmetic and source selection (purely combinational).
module npc_sel
    import mips_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_ext_sh,
    input  logic [25:0] i_jidx,
    input  logic [31:0] i_rs_val,
    input  logic        i_br,
    input  logic        i_zero,
    input  logic        i_jmp,
    input  logic        i_jr,
    output logic [31:0] o_pc4,
    output logic [31:0] o_btarget,
    output logic [31:0] o_jtarget,
    output logic [31:0] o_jrtarget,
    output npc_sel_t    o_sel,
    output logic [31:0] o_npc,
    output logic        o_redirect_comb,
    output logic        o_addr_err_comb
);

    assign o_pc4      = i_pc + 32'd4;
    assign o_btarget  = o_pc4 + i_ext_sh;
    assign o_jtarget  = {o_pc4[31:28], i_jidx, 2'b00};
    assign o_jrtarget = {i_rs_val[31:2], 2'b00};

    always_comb begin
        o_sel = SEL_PC4;
        if (i_jr)
            o_sel = SEL_JR;
        else if (i_jmp)
            o_sel = SEL_J;
        else if (i_br && i_zero)
            o_sel = SEL_BR;
    end

    always_comb begin
        o_npc = o_pc4;
        case (o_sel)
            SEL_BR:  o_npc = o_btarget;
            SEL_J:   o_npc = o_jtarget;
            SEL_JR:  o_npc = o_jrtarget;
            default: o_npc = o_pc4;
        endcase
    end

    // A taken branch with zero offset lands on pc4 and is not a redirect.
    assign o_redirect_comb = (o_sel != SEL_PC4)
                           && !(o_sel == SEL_BR && i_ext_sh == 32'd0);
    assign o_addr_err_comb = (o_sel == SEL_JR) && (i_rs_val[1:0] != 2'b00);

endmodule

// File: rtl/npc_unit.sv
// PC register, fetch FSM and IR latch for the multicycle MIPS datapath.
module npc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int          BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_sh,
    input  logic [25:0] jidx,
    input  logic [31:0] rs_val,
    input  logic        br,
    input  logic        zero,
    input  logic        jmp,
    input  logic        jr,
    input  logic        ctl_valid,
    input  logic        stall,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ack,
    input  logic [31:0] if_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        redirect,
    output logic        addr_err
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_redirect;
    logic        r_addr_err;

    logic        w_if_req;
    logic        w_ir_ld;
    logic        w_pc_ld;
    logic        w_cnt_inc;
    logic [31:0] w_pc4;
    logic [31:0] w_btarget;
    logic [31:0] w_jtarget;
    logic [31:0] w_jrtarget;
    npc_sel_t    w_sel;
    logic [31:0] w_npc;
    logic        w_redirect_comb;
    logic        w_addr_err_comb;

    npc_sel u_npc_sel (
        .i_pc            (r_pc),
        .i_ext_sh        (ext_sh),
        .i_jidx          (jidx),
        .i_rs_val        (rs_val),
        .i_br            (br),
        .i_zero          (zero),
        .i_jmp           (jmp),
        .i_jr            (jr),
        .o_pc4           (w_pc4),
        .o_btarget       (w_btarget),
        .o_jtarget       (w_jtarget),
        .o_jrtarget      (w_jrtarget),
        .o_sel           (w_sel),
        .o_npc           (w_npc),
        .o_redirect_comb (w_redirect_comb),
        .o_addr_err_comb (w_addr_err_comb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_if_req    = 1'b0;
        w_ir_ld     = 1'b0;
        w_pc_ld     = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                if (r_cnt == BOOT_LAST)
                    w_state_nxt = ST_FETCH;
                else
                    w_cnt_inc = 1'b1;
            end
            ST_FETCH: begin
                w_if_req = 1'b1;
                if (if_ack) begin
                    w_ir_ld     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ctl_valid && !stall) begin
                    w_pc_ld     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_ir_valid <= 1'b0;
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_ir_valid <= w_ir_ld;
            r_redirect <= w_pc_ld && w_redirect_comb;
            r_addr_err <= w_pc_ld && w_addr_err_comb;
            if (w_cnt_inc)
                r_cnt <= r_cnt + 4'd1;
            if (w_ir_ld)
                r_ir <= if_rdata;
            if (w_pc_ld)
                r_pc <= w_npc;
        end
    end

    assign if_req   = w_if_req;
    assign if_addr  = r_pc;
    assign pc       = r_pc;
    assign pc4      = w_pc4;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign redirect = r_redirect;
    assign addr_err = r_addr_err;

endmodule
